tl_serial_tx: RTL and testbench
===============================

TL_SERIAL_TX -- requirements
Module: tl_serial_tx

Interface
REQ-001 Parameter addr_mask, default 32'hF0000000, mask applied to a_address for device select.
REQ-002 Parameter addr_tag, default 32'h40000000, masked address value that selects this device.
REQ-003 Parameter clocks_per_bit, default 16, serial bit period in clocks; legal range >= 2.
REQ-004 Parameter fifo_depth, default 8, TX FIFO entries; power of two; legal range 2..16.
REQ-005 Port clock, input, 1, single clock; all state changes on its rising edge.
REQ-006 Port reset_in_n, input, 1, reset; asynchronous assert, active-low.
REQ-007 Port tla, input, tilelink_a, TileLink-UL A channel from the core bus.
REQ-008 Port bus_tld, output, tilelink_d, registered TileLink-UL D channel response.
REQ-009 Port ser_tx, output, 1, serial line, 8N1, idle high.

Function
REQ-010 Select: request is accepted when tla.a_valid=1 and (a_address & addr_mask)==addr_tag; no back-pressure, one request per clock.
REQ-011 Register map, offset a_address[3:2]:
- 0: TXDATA; write pushes a_data[7:0] when a_mask[0]=1; read returns 0.
- 1: STATUS, read-only; bit0 busy (state!=IDLE or FIFO non-empty), bit1 full, bit2 empty, bits[8:4] FIFO count; other bits 0.
- 2 and 3: read 0; writes ignored.
REQ-012 Write opcodes: PutFullData and PutPartialData. Read opcode: Get.
REQ-013 Response latency is exactly 1 clock: bus_tld.d_valid=1 in the cycle after an accepted request and 0 otherwise.
REQ-014 Response fields:
- d_opcode: AccessAckData for Get, AccessAck for Put.
- d_data: read value for Get, 0 for Put.
- d_size and d_source: echo the request.
REQ-015 Put to TXDATA while FIFO full SHALL drop the byte and respond with d_error=1; all other responses use d_error=0.
REQ-016 Fullness is evaluated against the count before this cycle's pop; a push in the same cycle as a pop at full is rejected.
REQ-017 The FIFO preserves order; count width is clog2(fifo_depth)+1.
REQ-018 TX FSM states: IDLE, START, DATA, STOP. A bit counter (0..clocks_per_bit-1) and a bit index (0..7) control timing.
REQ-019 IDLE, FIFO non-empty -> pop the head into the shift register and enter START the next cycle.
REQ-020 START: ser_tx=0 for clocks_per_bit clocks, then DATA.
REQ-021 DATA: ser_tx=shift[0] for clocks_per_bit clocks per bit, LSB first, 8 bits, then STOP.
REQ-022 STOP: ser_tx=1 for clocks_per_bit clocks. Then:
- FIFO non-empty: pop and go directly to START (back-to-back frames, no idle gap).
- FIFO empty: go to IDLE.
REQ-023 ser_tx=1 in IDLE. Frame length is exactly 10*clocks_per_bit clocks.
REQ-024 ser_tx is driven from a flop; no combinational path from tla to ser_tx or to bus_tld.
REQ-025 A Get of STATUS returns the values held before any same-cycle push or pop.

Reset
REQ-026 Assertion of reset_in_n=0 immediately sets:
- ser_tx=1, state=IDLE, FIFO empty.
- bus_tld.d_valid=0, d_error=0, all other bus_tld fields 0.
- Counters cleared.
REQ-027 Reset asserted mid-frame aborts the frame: ser_tx returns to 1 at once and all queued bytes are discarded.
REQ-028 Reset is released synchronously to clock externally; the first request after release is handled normally.

Verification
REQ-029 Reset, then Get STATUS at 0x40000004 -> one cycle later d_valid=1, AccessAckData, d_data=32'h00000004.
REQ-030 clocks_per_bit=4, Put 8'hA5 to 0x40000000 -> AccessAck, d_error=0; ser_tx, 4 clocks per level, reads 0,1,0,1,0,0,1,0,1,1; then idle high.
REQ-031 Put 9 bytes back-to-back (depth 8), no pop in progress -> ninth response d_error=1; exactly 8 frames emitted with no idle gap between them.
REQ-032 Put 2 bytes, then read STATUS during frame 1 -> busy=1, count=1; after 20*clocks_per_bit clocks -> STATUS=32'h00000004.
REQ-033 Assert reset_in_n=0 during DATA bit 3 -> ser_tx=1 in the same cycle; after release STATUS=32'h00000004 and no further frames are emitted.
REQ-034 Get to 0x50000000 (no match) -> d_valid stays 0 and no state change.

Source files
------------

// File: rtl/tl_serial_tx_if.sv
// TileLink-UL A (request) and D (response) channel bundles shared by the core bus
// and the serial transmitter.
interface tilelink_a;
  logic        a_valid;
  logic [2:0]  a_opcode;
  logic [1:0]  a_size;
  logic [7:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;

  modport master (output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data);
  modport slave  (input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data);
endinterface

interface tilelink_d;
  logic        d_valid;
  logic [2:0]  d_opcode;
  logic [1:0]  d_size;
  logic [7:0]  d_source;
  logic [31:0] d_data;
  logic        d_error;

  modport master (output d_valid, d_opcode, d_size, d_source, d_data, d_error);
  modport slave  (input  d_valid, d_opcode, d_size, d_source, d_data, d_error);
endinterface

// File: rtl/tl_serial_tx.sv
// TileLink-UL mapped 8N1 serial transmitter with a byte FIFO; every response and
// the serial line come straight from flops.
module tl_serial_tx #(
  parameter logic [31:0] addr_mask      = 32'hF000_0000,
  parameter logic [31:0] addr_tag       = 32'h4000_0000,
  parameter int unsigned clocks_per_bit = 16,
  parameter int unsigned fifo_depth     = 8
) (
  input  logic      clock,
  input  logic      reset_in_n,
  tilelink_a.slave  tla,
  tilelink_d.master bus_tld,
  output logic      ser_tx
);

  localparam int unsigned AW  = $clog2(fifo_depth);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned BCW = $clog2(clocks_per_bit);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(clocks_per_bit - 1);
  localparam logic [CW-1:0]  DEPTH    = CW'(fifo_depth);

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_e;

  state_e         state_q;
  logic [BCW-1:0] bit_cnt_q;
  logic [2:0]     bit_idx_q;
  logic [7:0]     shift_q;
  logic           ser_tx_q;

  logic [7:0]     fifo_q [fifo_depth];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  logic           d_valid_q, d_error_q;
  logic [2:0]     d_opcode_q;
  logic [1:0]     d_size_q;
  logic [7:0]     d_source_q;
  logic [31:0]    d_data_q;

  logic           sel_s, put_s, get_s, push_req_s, push_s, pop_s;
  logic           full_s, empty_s, busy_s, bit_end_s;
  logic [1:0]     off_s;
  logic [4:0]     cnt5_s;
  logic [31:0]    status_s, rd_data_s;
  logic           unused_s;

  assign unused_s = ^{tla.a_mask[3:1], tla.a_data[31:8]};

  // Request decode, FIFO bookkeeping and the pre-update STATUS snapshot
  always_comb begin
    sel_s      = tla.a_valid && ((tla.a_address & addr_mask) == addr_tag);
    put_s      = (tla.a_opcode == OP_PUT_FULL) || (tla.a_opcode == OP_PUT_PART);
    get_s      = (tla.a_opcode == OP_GET);
    off_s      = tla.a_address[3:2];
    empty_s    = (count_q == {CW{1'b0}});
    full_s     = (count_q == DEPTH);
    busy_s     = (state_q != IDLE) || !empty_s;
    bit_end_s  = (bit_cnt_q == BIT_LAST);
    push_req_s = sel_s && put_s && (off_s == 2'd0) && tla.a_mask[0];
    push_s     = push_req_s && !full_s;
    cnt5_s     = 5'(count_q);
    status_s   = {23'd0, cnt5_s, 1'b0, empty_s, full_s, busy_s};
    if (off_s == 2'd1) begin
      rd_data_s = status_s;
    end else begin
      rd_data_s = 32'd0;
    end
    case (state_q)
      IDLE:    pop_s = !empty_s;
      STOP:    pop_s = bit_end_s && !empty_s;
      default: pop_s = 1'b0;
    endcase
    wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    if (push_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // FIFO storage; validity is tracked by the pointers, so no reset is needed here
  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_q[wr_ptr_q] <= tla.a_data[7:0];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock or negedge reset_in_n) begin
    if (!reset_in_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Transmit FSM; ser_tx_q is loaded together with each state change
  always_ff @(posedge clock or negedge reset_in_n) begin
    if (!reset_in_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= {BCW{1'b0}};
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      ser_tx_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          bit_cnt_q <= {BCW{1'b0}};
          bit_idx_q <= 3'd0;
          if (pop_s) begin
            shift_q  <= fifo_q[rd_ptr_q];
            state_q  <= START;
            ser_tx_q <= 1'b0;
          end else begin
            ser_tx_q <= 1'b1;
          end
        end
        START: begin
          if (bit_end_s) begin
            bit_cnt_q <= {BCW{1'b0}};
            bit_idx_q <= 3'd0;
            state_q   <= DATA;
            ser_tx_q  <= shift_q[0];
          end else begin
            bit_cnt_q <= bit_cnt_q + BCW'(1);
          end
        end
        DATA: begin
          if (bit_end_s) begin
            bit_cnt_q <= {BCW{1'b0}};
            if (bit_idx_q == 3'd7) begin
              state_q  <= STOP;
              ser_tx_q <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              ser_tx_q  <= shift_q[1];
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + BCW'(1);
          end
        end
        STOP: begin
          if (bit_end_s) begin
            bit_cnt_q <= {BCW{1'b0}};
            if (pop_s) begin
              shift_q  <= fifo_q[rd_ptr_q];
              state_q  <= START;
              ser_tx_q <= 1'b0;
            end else begin
              state_q  <= IDLE;
              ser_tx_q <= 1'b1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + BCW'(1);
          end
        end
        default: begin
          state_q  <= IDLE;
          ser_tx_q <= 1'b1;
        end
      endcase
    end
  end

  // D-channel response, one clock after each selected request
  always_ff @(posedge clock or negedge reset_in_n) begin
    if (!reset_in_n) begin
      d_valid_q  <= 1'b0;
      d_opcode_q <= 3'd0;
      d_data_q   <= 32'd0;
      d_size_q   <= 2'd0;
      d_source_q <= 8'd0;
      d_error_q  <= 1'b0;
    end else begin
      d_valid_q <= sel_s;
      if (sel_s) begin
        d_opcode_q <= get_s ? OP_ACK_DATA : OP_ACK;
        d_data_q   <= get_s ? rd_data_s : 32'd0;
        d_size_q   <= tla.a_size;
        d_source_q <= tla.a_source;
        d_error_q  <= push_req_s && full_s;
      end else begin
        d_opcode_q <= 3'd0;
        d_data_q   <= 32'd0;
        d_size_q   <= 2'd0;
        d_source_q <= 8'd0;
        d_error_q  <= 1'b0;
      end
    end
  end

  assign ser_tx           = ser_tx_q;
  assign bus_tld.d_valid  = d_valid_q;
  assign bus_tld.d_opcode = d_opcode_q;
  assign bus_tld.d_data   = d_data_q;
  assign bus_tld.d_size   = d_size_q;
  assign bus_tld.d_source = d_source_q;
  assign bus_tld.d_error  = d_error_q;

endmodule

// File: tb/tb_tl_serial_tx.sv
// Directed bench for tl_serial_tx: register-map vector table plus hand-written
// serial-timing, FIFO-full, reset-abort and no-match sequences.
module tb_tl_serial_tx;

  localparam int CPB = 4;
  localparam logic [2:0] PUTF = 3'd0, PUTP = 3'd1, GET = 3'd4;
  localparam logic [2:0] ACK = 3'd0, ACKD = 3'd1;

  logic clock = 1'b0;
  logic reset_in_n = 1'b0;
  logic ser_tx;

  tilelink_a tla ();
  tilelink_d bus_tld ();

  tl_serial_tx #(.clocks_per_bit(CPB), .fifo_depth(8)) dut (
    .clock(clock), .reset_in_n(reset_in_n), .tla(tla), .bus_tld(bus_tld), .ser_tx(ser_tx)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  logic        r_valid, r_error;
  logic [2:0]  r_opcode;
  logic [31:0] r_data;
  logic [1:0]  r_size;
  logic [7:0]  r_source;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [1:0]  size;
    logic [7:0]  src;
    logic        exp_valid;
    logic [2:0]  exp_op;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, input logic [1:0] size, input logic [7:0] src);
    tla.a_valid = 1'b1; tla.a_opcode = op; tla.a_address = addr;
    tla.a_data = data; tla.a_mask = mask; tla.a_size = size; tla.a_source = src;
  endtask

  task automatic capture();
    r_valid = bus_tld.d_valid; r_opcode = bus_tld.d_opcode; r_data = bus_tld.d_data;
    r_error = bus_tld.d_error; r_size = bus_tld.d_size; r_source = bus_tld.d_source;
  endtask

  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input logic [1:0] size, input logic [7:0] src);
    @(negedge clock);
    drive_a(op, addr, data, mask, size, src);
    @(negedge clock);
    tla.a_valid = 1'b0;
    capture();
  endtask

  // Finds the next start bit within limit cycles and samples the frame mid-bit.
  task automatic wait_frame(input int limit, output logic found, output logic [7:0] b,
                            output logic stop, output int gap);
    gap = 0; b = 8'd0; stop = 1'b0;
    while (ser_tx !== 1'b0 && gap < limit) begin
      @(negedge clock);
      gap++;
    end
    found = (ser_tx === 1'b0);
    if (found) begin
      for (int i = 1; i <= 10 * CPB; i++) begin
        @(negedge clock);
        for (int k = 0; k < 8; k++)
          if (i == CPB * (k + 1) + CPB / 2) b[k] = ser_tx;
        if (i == 9 * CPB + CPB / 2) stop = ser_tx;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] pat;
    logic found, stop;
    logic [7:0] b;
    int gap, lows;

    vecs[0] = '{GET,  32'h4000_0004, 32'h0,  4'hF,    2'd2, 8'h11, 1'b1, ACKD, 32'h4, 1'b0};
    vecs[1] = '{GET,  32'h4000_0000, 32'h0,  4'hF,    2'd2, 8'h12, 1'b1, ACKD, 32'h0, 1'b0};
    vecs[2] = '{GET,  32'h4000_0008, 32'h0,  4'hF,    2'd2, 8'h13, 1'b1, ACKD, 32'h0, 1'b0};
    vecs[3] = '{GET,  32'h4000_000C, 32'h0,  4'hF,    2'd2, 8'h14, 1'b1, ACKD, 32'h0, 1'b0};
    vecs[4] = '{PUTF, 32'h4000_0008, 32'h55, 4'hF,    2'd2, 8'h15, 1'b1, ACK,  32'h0, 1'b0};
    vecs[5] = '{PUTP, 32'h4000_0000, 32'h77, 4'b1110, 2'd0, 8'h16, 1'b1, ACK,  32'h0, 1'b0};
    vecs[6] = '{GET,  32'h5000_0004, 32'h0,  4'hF,    2'd2, 8'h17, 1'b0, ACK,  32'h0, 1'b0};
    vecs[7] = '{PUTF, 32'h5000_0000, 32'h33, 4'hF,    2'd2, 8'h18, 1'b0, ACK,  32'h0, 1'b0};
    vecs[8] = '{GET,  32'h4ABC_DE04, 32'h0,  4'hF,    2'd1, 8'hA7, 1'b1, ACKD, 32'h4, 1'b0};
    vecs[9] = '{GET,  32'h4000_0004, 32'h0,  4'hF,    2'd2, 8'h19, 1'b1, ACKD, 32'h4, 1'b0};

    tla.a_valid = 1'b0; tla.a_opcode = 3'd0; tla.a_address = 32'd0; tla.a_data = 32'd0;
    tla.a_mask = 4'd0; tla.a_size = 2'd0; tla.a_source = 8'd0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_ser_tx", ser_tx, 1'b1);
    check("rst_d_valid", bus_tld.d_valid, 1'b0);
    check("rst_d_error", bus_tld.d_error, 1'b0);
    check("rst_d_data", bus_tld.d_data, 32'h0);
    reset_in_n = 1'b1;

    // Register map, no-match and echo vectors
    for (int v = 0; v < 10; v++) begin
      do_req(vecs[v].op, vecs[v].addr, vecs[v].data, vecs[v].mask, vecs[v].size, vecs[v].src);
      check($sformatf("v%0d_valid", v), r_valid, vecs[v].exp_valid);
      if (vecs[v].exp_valid) begin
        check($sformatf("v%0d_opcode", v), r_opcode, vecs[v].exp_op);
        check($sformatf("v%0d_data", v), r_data, vecs[v].exp_data);
        check($sformatf("v%0d_error", v), r_error, vecs[v].exp_err);
        check($sformatf("v%0d_size", v), r_size, vecs[v].size);
        check($sformatf("v%0d_source", v), r_source, vecs[v].src);
      end
      @(negedge clock);
      check($sformatf("v%0d_valid_drop", v), bus_tld.d_valid, 1'b0);
    end
    check("idle_line_after_vectors", ser_tx, 1'b1);

    // Single byte 8'hA5, cycle-exact waveform
    do_req(PUTF, 32'h4000_0000, 32'hA5, 4'hF, 2'd0, 8'h02);
    check("a5_valid", r_valid, 1'b1);
    check("a5_opcode", r_opcode, ACK);
    check("a5_error", r_error, 1'b0);
    check("a5_pre_start", ser_tx, 1'b1);
    pat = 10'b11_0100_1010;
    for (int c = 0; c < 10 * CPB; c++) begin
      @(negedge clock);
      check($sformatf("a5_cycle%0d", c), ser_tx, pat[c / CPB]);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      check($sformatf("a5_idle%0d", c), ser_tx, 1'b1);
    end

    // Two bytes, STATUS during frame 1 then after both frames
    do_req(PUTF, 32'h4000_0000, 32'h11, 4'hF, 2'd0, 8'h03);
    do_req(PUTF, 32'h4000_0000, 32'h22, 4'hF, 2'd0, 8'h04);
    do_req(GET, 32'h4000_0004, 32'h0, 4'hF, 2'd2, 8'h05);
    check("two_status_mid", r_data, 32'h0000_0011);
    repeat (20 * CPB) @(negedge clock);
    do_req(GET, 32'h4000_0004, 32'h0, 4'hF, 2'd2, 8'h06);
    check("two_status_end", r_data, 32'h0000_0004);

    // Fill FIFO while a frame is in DATA (no pop during the burst)
    do_req(PUTF, 32'h4000_0000, 32'hFF, 4'hF, 2'd0, 8'h07);
    repeat (6) @(negedge clock);
    @(negedge clock);
    drive_a(PUTF, 32'h4000_0000, 32'h01, 4'hF, 2'd0, 8'h20);
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      capture();
      if (i < 8) drive_a(PUTF, 32'h4000_0000, 32'(i + 2), 4'hF, 2'd0, 8'(8'h21 + i));
      else tla.a_valid = 1'b0;
      check($sformatf("burst%0d_error", i), r_error, (i == 8) ? 1'b1 : 1'b0);
    end
    do_req(GET, 32'h4000_0004, 32'h0, 4'hF, 2'd2, 8'h08);
    check("burst_status_full", r_data, 32'h0000_0083);
    for (int f = 0; f < 8; f++) begin
      wait_frame(200, found, b, stop, gap);
      check($sformatf("burst_frame%0d_found", f), found, 1'b1);
      check($sformatf("burst_frame%0d_byte", f), b, 32'(f + 1));
      check($sformatf("burst_frame%0d_stop", f), stop, 1'b1);
      if (f > 0) check($sformatf("burst_frame%0d_gap", f), gap, 0);
    end
    wait_frame(100, found, b, stop, gap);
    check("burst_no_ninth_frame", found, 1'b0);

    // Reset during DATA bit 3 aborts frame and flushes queue
    do_req(PUTF, 32'h4000_0000, 32'h00, 4'hF, 2'd0, 8'h09);
    do_req(PUTF, 32'h4000_0000, 32'h00, 4'hF, 2'd0, 8'h0A);
    repeat (16) @(negedge clock);
    #2;
    check("abort_line_low_before", ser_tx, 1'b0);
    reset_in_n = 1'b0;
    #1;
    check("abort_line_high", ser_tx, 1'b1);
    check("abort_d_valid", bus_tld.d_valid, 1'b0);
    repeat (2) @(negedge clock);
    reset_in_n = 1'b1;
    do_req(GET, 32'h4000_0004, 32'h0, 4'hF, 2'd2, 8'h0B);
    check("abort_status", r_data, 32'h0000_0004);
    lows = 0;
    repeat (60) begin
      @(negedge clock);
      if (ser_tx !== 1'b1) lows++;
    end
    check("abort_no_frames", lows, 0);

    // Non-matching Put leaves state untouched
    do_req(PUTF, 32'h5000_0000, 32'h5A, 4'hF, 2'd0, 8'h0C);
    check("nomatch_valid", r_valid, 1'b0);
    do_req(GET, 32'h4000_0004, 32'h0, 4'hF, 2'd2, 8'h0D);
    check("nomatch_status", r_data, 32'h0000_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
